// File: rtl/demo2_waterled_nios2_mult_pkg.sv
// demo2_waterled_nios2_mult_pkg: op encoding, latency constant and signedness helpers for the multiplier
package demo2_waterled_nios2_mult_pkg;
  typedef enum logic [1:0] {MUL = 2'b00, MULXSS = 2'b01, MULXSU = 2'b10, MULXUU = 2'b11} mult_op_e;
`ifdef MULT_OUT_REG_EN
  localparam int MULT_LATENCY = 3;
`else
  localparam int MULT_LATENCY = 2;
`endif
  function automatic logic op_a_signed(mult_op_e op);
    return op == MULXSS || op == MULXSU;
  endfunction
  function automatic logic op_b_signed(mult_op_e op);
    return op == MULXSS;
  endfunction
endpackage

// File: rtl/demo2_waterled_nios2_cpu_mult_pp.sv
// demo2_waterled_nios2_cpu_mult_pp: one registered W x W signed product with enable and async clear
module demo2_waterled_nios2_cpu_mult_pp #(
  parameter int W = 17
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  logic [2*W-1:0] p_d, p_q;
  // the low 2W bits of the product of sign-extended operands equal the signed product
  always_comb p_d = en ? {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b} : p_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) p_q <= '0;
    else p_q <= p_d;
  assign p = p_q;
endmodule

// File: rtl/demo2_waterled_nios2_cpu_mult_pipe.sv
// demo2_waterled_nios2_cpu_mult_pipe: 2-stage split-operand multiplier with tag pass-through.
// MULT_OUT_REG_EN adds a third output register stage.
module demo2_waterled_nios2_cpu_mult_pipe
  import demo2_waterled_nios2_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              E_valid,
  input  logic [1:0]        E_op,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic [TAG_W-1:0]  E_tag,
  input  logic              M_en,
  output logic [DATA_W-1:0] W_result,
  output logic              W_valid,
  output logic [TAG_W-1:0]  W_tag
);
  localparam int HALF_W = DATA_W / 2;
  localparam int PW     = 2 * HALF_W + 2;
  logic              a_s, b_s;
  logic [HALF_W:0]   a_lo, a_hi, b_lo, b_hi;
  logic [PW-1:0]     p_ll, p_lh, p_hl, p_hh;
  logic [2*DATA_W-1:0] prod;
  mult_op_e          op1_d, op1_q;
  logic [TAG_W-1:0]  tag1_d, tag1_q, tag2_d, tag2_q;
  logic              v1_d, v1_q, v2_d, v2_q;
  logic [DATA_W-1:0] res2_d, res2_q;
  // lower halves are magnitudes; only upper halves carry the operand sign
  always_comb begin
    a_s  = op_a_signed(mult_op_e'(E_op));
    b_s  = op_b_signed(mult_op_e'(E_op));
    a_lo = {1'b0, E_src1[HALF_W-1:0]};
    b_lo = {1'b0, E_src2[HALF_W-1:0]};
    a_hi = {a_s & E_src1[DATA_W-1], E_src1[DATA_W-1:HALF_W]};
    b_hi = {b_s & E_src2[DATA_W-1], E_src2[DATA_W-1:HALF_W]};
  end
  demo2_waterled_nios2_cpu_mult_pp #(.W(HALF_W + 1)) u_pp_ll (.clk(clk), .reset_n(reset_n), .en(M_en), .a(a_lo), .b(b_lo), .p(p_ll));
  demo2_waterled_nios2_cpu_mult_pp #(.W(HALF_W + 1)) u_pp_lh (.clk(clk), .reset_n(reset_n), .en(M_en), .a(a_lo), .b(b_hi), .p(p_lh));
  demo2_waterled_nios2_cpu_mult_pp #(.W(HALF_W + 1)) u_pp_hl (.clk(clk), .reset_n(reset_n), .en(M_en), .a(a_hi), .b(b_lo), .p(p_hl));
  demo2_waterled_nios2_cpu_mult_pp #(.W(HALF_W + 1)) u_pp_hh (.clk(clk), .reset_n(reset_n), .en(M_en), .a(a_hi), .b(b_hi), .p(p_hh));
  always_comb begin
    prod   = {{(2*DATA_W-PW){p_ll[PW-1]}}, p_ll}
           + ({{(2*DATA_W-PW){p_lh[PW-1]}}, p_lh} << HALF_W)
           + ({{(2*DATA_W-PW){p_hl[PW-1]}}, p_hl} << HALF_W)
           + ({{(2*DATA_W-PW){p_hh[PW-1]}}, p_hh} << DATA_W);
    op1_d  = M_en ? mult_op_e'(E_op) : op1_q;
    tag1_d = M_en ? E_tag : tag1_q;
    v1_d   = M_en ? E_valid : v1_q;
    res2_d = M_en ? (op1_q == MUL ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W]) : res2_q;
    tag2_d = M_en ? tag1_q : tag2_q;
    v2_d   = M_en ? v1_q : v2_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      op1_q  <= MUL;
      tag1_q <= '0;
      v1_q   <= 1'b0;
      res2_q <= '0;
      tag2_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      op1_q  <= op1_d;
      tag1_q <= tag1_d;
      v1_q   <= v1_d;
      res2_q <= res2_d;
      tag2_q <= tag2_d;
      v2_q   <= v2_d;
    end
`ifdef MULT_OUT_REG_EN
  logic [DATA_W-1:0] res3_d, res3_q;
  logic [TAG_W-1:0]  tag3_d, tag3_q;
  logic              v3_d, v3_q;
  always_comb begin
    res3_d = M_en ? res2_q : res3_q;
    tag3_d = M_en ? tag2_q : tag3_q;
    v3_d   = M_en ? v2_q : v3_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      res3_q <= '0;
      tag3_q <= '0;
      v3_q   <= 1'b0;
    end else begin
      res3_q <= res3_d;
      tag3_q <= tag3_d;
      v3_q   <= v3_d;
    end
  assign W_result = res3_q;
  assign W_tag    = tag3_q;
  assign W_valid  = v3_q;
`else
  assign W_result = res2_q;
  assign W_tag    = tag2_q;
  assign W_valid  = v2_q;
`endif
endmodule

// File: tb/tb_demo2_waterled_nios2_cpu_mult_pipe.sv
// tb_demo2_waterled_nios2_cpu_mult_pipe: directed and random checks against a 64-bit arithmetic reference
module tb_demo2_waterled_nios2_cpu_mult_pipe;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        E_valid;
  logic [1:0]  E_op;
  logic [31:0] E_src1, E_src2;
  logic [4:0]  E_tag;
  logic        M_en;
  logic [31:0] W_result;
  logic        W_valid;
  logic [4:0]  W_tag;
  int checks = 0;
  int passed = 0;
  bit mon = 1'b0;

  demo2_waterled_nios2_cpu_mult_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .E_valid(E_valid), .E_op(E_op), .E_src1(E_src1),
    .E_src2(E_src2), .E_tag(E_tag), .M_en(M_en), .W_result(W_result), .W_valid(W_valid), .W_tag(W_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return op == 2'b00 ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // expected-result pipeline: entry [0] is the op accepted last advance, [1] is what W_* must show
  typedef struct packed {logic v; logic [31:0] r; logic [4:0] t;} exp_t;
  exp_t m0, m1;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m0 <= '0;
      m1 <= '0;
    end else if (M_en) begin
      m1 <= m0;
      m0 <= '{E_valid, ref_mul(E_op, E_src1, E_src2), E_tag};
    end

  always @(negedge clk)
    if (mon) begin
      chk("model_valid", {31'b0, W_valid}, {31'b0, m1.v});
      if (m1.v) begin
        chk("model_result", W_result, m1.r);
        chk("model_tag", {27'b0, W_tag}, {27'b0, m1.t});
      end
    end

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic en);
    E_valid = v;
    E_op    = op;
    E_src1  = a;
    E_src2  = b;
    E_tag   = t;
    M_en    = en;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic v, input logic [31:0] r, input logic [4:0] t);
    chk({nm, "_v"}, {31'b0, W_valid}, {31'b0, v});
    if (v) begin
      chk({nm, "_r"}, W_result, r);
      chk({nm, "_t"}, {27'b0, W_tag}, {27'b0, t});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    E_valid = 1'b0; E_op = 2'b00; E_src1 = '0; E_src2 = '0; E_tag = '0; M_en = 1'b1;
    #1 mon = 1'b1;
    chk("reset_valid", {31'b0, W_valid}, 32'd0);
    chk("reset_result", W_result, 32'd0);
    chk("reset_tag", {27'b0, W_tag}, 5'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // all-ones operands through every op, back to back
    drive(1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1);
    drive(1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1);
    lit("t1_mul", 1, 32'h00000001, 5'd1);
    drive(1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1);
    lit("t1_mulxuu", 1, 32'hFFFFFFFE, 5'd2);
    drive(1, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1);
    lit("t1_mulxss", 1, 32'h00000000, 5'd3);
    drive(1, 2'b01, 32'h80000000, 32'h80000000, 5'd5, 1);
    lit("t1_mulxsu", 1, 32'hFFFFFFFF, 5'd4);
    drive(1, 2'b00, 32'h00012345, 32'h00010000, 5'd6, 1);
    lit("t2_mulxss_min", 1, 32'h40000000, 5'd5);
    drive(0, 2'b00, 0, 0, 5'd0, 1);
    lit("t2_mul_shift", 1, 32'h23450000, 5'd6);
    drive(0, 2'b00, 0, 0, 5'd0, 1);
    lit("t2_bubble", 0, 0, 0);
    // stall behaviour
    drive(1, 2'b00, 32'd3, 32'd5, 5'd7, 1);
    lit("t3_pre", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b11, 32'd9, 32'd9, 5'd11, 0);
      lit("t3_stall_empty", 0, 0, 0);
    end
    drive(0, 2'b00, 0, 0, 5'd0, 1);
    lit("t3_out", 1, 32'd15, 5'd7);
    for (int i = 0; i < 2; i++) begin
      drive(1, 2'b11, 32'd9, 32'd9, 5'd12, 0);
      lit("t3_stall_hold", 1, 32'd15, 5'd7);
    end
    drive(0, 2'b00, 0, 0, 5'd0, 1);
    lit("t3_no_capture_a", 0, 0, 0);
    drive(0, 2'b00, 0, 0, 5'd0, 1);
    lit("t3_no_capture_b", 0, 0, 0);
    // alternating valid
    drive(1, 2'b00, 32'd2, 32'd3, 5'd3, 1);
    drive(0, 2'b00, 0, 0, 5'd0, 1);
    lit("t4_first", 1, 32'd6, 5'd3);
    drive(1, 2'b00, 32'd4, 32'd5, 5'd4, 1);
    lit("t4_gap", 0, 0, 0);
    drive(0, 2'b00, 0, 0, 5'd0, 1);
    lit("t4_second", 1, 32'd20, 5'd4);
    // reset while an op sits in S1 and a valid result is on the outputs
    drive(1, 2'b00, 32'd6, 32'd7, 5'd8, 1);
    drive(1, 2'b00, 32'd7, 32'd7, 5'd9, 1);
    lit("t5_before", 1, 32'd42, 5'd8);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'b0, W_valid}, 32'd0);
    chk("t5_rst_result", W_result, 32'd0);
    chk("t5_rst_tag", {27'b0, W_tag}, 5'd0);
    @(negedge clk);
    E_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b00, 0, 0, 5'd0, 1);
      lit("t5_dropped", 0, 0, 0);
    end
    // random traffic, checked by the model process every cycle
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0);
    end
    mon = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
